// File: rtl/acf_stream_engine.sv
// Streaming integer autocorrelation engine: accumulates R[0..LAGS] over sample blocks,
// normalises each block by a common right shift and drains it one lag per beat.
module acf_stream_engine #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned LAGS         = 12,
    parameter int unsigned MAX_BLOCK    = 4096,
    parameter int unsigned OUT_WIDTH    = 32
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic                          iEnable,
    input  logic [$clog2(MAX_BLOCK):0]    iBlockSize,
    input  logic                          iValid,
    output logic                          oReady,
    input  logic [SAMPLE_WIDTH-1:0]       iSample,
    output logic                          oValid,
    input  logic                          iOutReady,
    output logic [OUT_WIDTH-1:0]          oAcf,
    output logic [$clog2(LAGS+1)-1:0]     oLag,
    output logic [5:0]                    oShift,
    output logic                          oLast,
    output logic                          oBlockDone
);

    localparam int unsigned PROD_WIDTH = 2 * SAMPLE_WIDTH;
    localparam int unsigned ACC_WIDTH  = 2 * SAMPLE_WIDTH + $clog2(MAX_BLOCK) + 1;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_BLOCK) + 1;
    localparam int unsigned LAG_WIDTH  = $clog2(LAGS + 1);
    localparam int unsigned MSB_WIDTH  = $clog2(ACC_WIDTH + 1);

    typedef enum logic [1:0] {ACCUM, FLUSH, XFER, STALL} acc_state_t;
    typedef enum logic       {EMPTY, SEND}               out_state_t;

    acc_state_t acc_state_q, acc_state_d;
    out_state_t out_state_q, out_state_d;
    logic       flush_cnt_q, flush_cnt_d;

    logic signed [SAMPLE_WIDTH-1:0] tap_q  [1:LAGS];
    logic signed [SAMPLE_WIDTH-1:0] tap_d  [1:LAGS];
    logic signed [PROD_WIDTH-1:0]   prod_q [0:LAGS];
    logic signed [PROD_WIDTH-1:0]   prod_d [0:LAGS];
    logic signed [ACC_WIDTH-1:0]    acc_q  [0:LAGS];
    logic signed [ACC_WIDTH-1:0]    acc_d  [0:LAGS];
    logic [OUT_WIDTH-1:0]           bank_q [0:LAGS];
    logic [OUT_WIDTH-1:0]           bank_d [0:LAGS];
    logic [OUT_WIDTH-1:0]           norm_val [0:LAGS];

    logic                 prod_vld_q, prod_vld_d;
    logic [CNT_WIDTH-1:0] count_q, count_d, size_q, size_d, in_size, blk_size;
    logic                 ready_q, ready_d, valid_q, valid_d, last_q, last_d;
    logic                 block_done_q, block_done_d;
    logic [OUT_WIDTH-1:0] acf_q, acf_d;
    logic [LAG_WIDTH-1:0] lag_q, lag_d, nxt_lag;
    logic [5:0]           shift_q, shift_d, norm_shift;
    logic [MSB_WIDTH-1:0] msb_len;

    logic accept, last_accept, hs, bank_free, xfer_fire;
    logic signed [SAMPLE_WIDTH-1:0] sample_s;

    assign sample_s    = $signed(iSample);
    assign accept      = iEnable & iValid & ready_q;
    assign in_size     = (iBlockSize == '0 || iBlockSize > CNT_WIDTH'(MAX_BLOCK))
                         ? CNT_WIDTH'(MAX_BLOCK) : iBlockSize;
    assign blk_size    = (count_q == '0) ? in_size : size_q;
    assign last_accept = accept & (count_q + CNT_WIDTH'(1) == blk_size);
    assign hs          = valid_q & iOutReady;
    // The bank is free if empty or its final beat is handed off this very cycle.
    assign bank_free   = (out_state_q == EMPTY) | (hs & last_q);

    // Accumulator FSM: state register
    always_ff @(posedge iClock) begin
        if (iReset) begin
            acc_state_q <= ACCUM;
            flush_cnt_q <= 1'b0;
        end else if (iEnable) begin
            acc_state_q <= acc_state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Accumulator FSM: next state
    always_comb begin
        acc_state_d = acc_state_q;
        flush_cnt_d = flush_cnt_q;
        case (acc_state_q)
            ACCUM: if (last_accept) begin
                acc_state_d = FLUSH;
                flush_cnt_d = 1'b0;
            end
            FLUSH: begin
                if (flush_cnt_q) acc_state_d = XFER;
                flush_cnt_d = 1'b1;
            end
            XFER:    acc_state_d = bank_free ? ACCUM : STALL;
            STALL:   if (bank_free) acc_state_d = XFER;
            default: acc_state_d = ACCUM;
        endcase
    end

    // Accumulator FSM: outputs
    always_comb begin
        ready_d      = (acc_state_d == ACCUM);
        xfer_fire    = iEnable & (acc_state_q == XFER) & bank_free;
        block_done_d = xfer_fire;
    end

    // Sample pipeline: history taps, products, accumulators
    always_comb begin
        tap_d      = tap_q;
        acc_d      = acc_q;
        count_d    = count_q;
        size_d     = size_q;
        prod_vld_d = accept;
        for (int k = 0; k <= LAGS; k++) begin
            prod_d[k] = prod_q[k];
        end
        if (accept) begin
            prod_d[0] = PROD_WIDTH'(sample_s) * PROD_WIDTH'(sample_s);
            for (int k = 1; k <= LAGS; k++) begin
                prod_d[k] = PROD_WIDTH'(sample_s) * PROD_WIDTH'(tap_q[k]);
            end
            tap_d[1] = sample_s;
            for (int k = 2; k <= LAGS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
            count_d = count_q + CNT_WIDTH'(1);
            if (count_q == '0) size_d = in_size;
        end
        if (prod_vld_q) begin
            for (int k = 0; k <= LAGS; k++) begin
                acc_d[k] = acc_q[k] + ACC_WIDTH'(prod_q[k]);
            end
        end
        if (xfer_fire) begin
            count_d = '0;
            for (int k = 1; k <= LAGS; k++) tap_d[k] = '0;
            for (int k = 0; k <= LAGS; k++) acc_d[k] = '0;
        end
    end

    // Normalisation: shift so R[0] fits a signed OUT_WIDTH value; R[0] is never negative.
    always_comb begin
        msb_len = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (acc_q[0][i]) msb_len = MSB_WIDTH'(i + 1);
        end
        norm_shift = '0;
        if (msb_len > MSB_WIDTH'(OUT_WIDTH - 1)) norm_shift = 6'(msb_len - MSB_WIDTH'(OUT_WIDTH - 1));
        for (int k = 0; k <= LAGS; k++) begin
            norm_val[k] = OUT_WIDTH'(acc_q[k] >>> norm_shift);
        end
    end

    // Output FSM: state register
    always_ff @(posedge iClock) begin
        if (iReset)       out_state_q <= EMPTY;
        else if (iEnable) out_state_q <= out_state_d;
    end

    // Output FSM: next state
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            EMPTY:   if (xfer_fire) out_state_d = SEND;
            SEND:    if (hs && last_q && !xfer_fire) out_state_d = EMPTY;
            default: out_state_d = EMPTY;
        endcase
    end

    // Output FSM: beat registers
    always_comb begin
        bank_d  = bank_q;
        acf_d   = acf_q;
        lag_d   = lag_q;
        shift_d = shift_q;
        last_d  = last_q;
        nxt_lag = lag_q + LAG_WIDTH'(1);
        valid_d = (out_state_d == SEND);
        if (xfer_fire) begin
            bank_d  = norm_val;
            acf_d   = norm_val[0];
            lag_d   = '0;
            shift_d = norm_shift;
            last_d  = (LAGS == 0);
        end else if (hs && !last_q) begin
            acf_d  = bank_q[nxt_lag];
            lag_d  = nxt_lag;
            last_d = (nxt_lag == LAG_WIDTH'(LAGS));
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            prod_vld_q   <= 1'b0;
            count_q      <= '0;
            size_q       <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            acf_q        <= '0;
            lag_q        <= '0;
            shift_q      <= '0;
            block_done_q <= 1'b0;
            for (int k = 1; k <= LAGS; k++) tap_q[k] <= '0;
            for (int k = 0; k <= LAGS; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
                bank_q[k] <= '0;
            end
        end else begin
            block_done_q <= block_done_d;
            if (iEnable) begin
                prod_vld_q <= prod_vld_d;
                count_q    <= count_d;
                size_q     <= size_d;
                ready_q    <= ready_d;
                valid_q    <= valid_d;
                last_q     <= last_d;
                acf_q      <= acf_d;
                lag_q      <= lag_d;
                shift_q    <= shift_d;
                tap_q      <= tap_d;
                prod_q     <= prod_d;
                acc_q      <= acc_d;
                bank_q     <= bank_d;
            end
        end
    end

    assign oReady     = ready_q;
    assign oValid     = valid_q;
    assign oAcf       = acf_q;
    assign oLag       = lag_q;
    assign oShift     = shift_q;
    assign oLast      = last_q;
    assign oBlockDone = block_done_q;

endmodule

// File: tb/tb_acf_stream_engine.sv
// Directed bench for acf_stream_engine with a block-level autocorrelation model and per-beat scoreboard.
module tb_acf_stream_engine;

    localparam int SW   = 16;
    localparam int LAGS = 2;
    localparam int MAXB = 4096;
    localparam int OW   = 16;
    localparam int BSW  = $clog2(MAXB) + 1;
    localparam int LW   = $clog2(LAGS + 1);

    logic iClock = 1'b0;
    logic iReset, iEnable, iValid, iOutReady;
    logic oReady, oValid, oLast, oBlockDone;
    logic [BSW-1:0] iBlockSize;
    logic signed [SW-1:0] iSample;
    logic signed [OW-1:0] oAcf;
    logic [LW-1:0] oLag;
    logic [5:0] oShift;

    always #5 iClock = ~iClock;

    acf_stream_engine #(
        .SAMPLE_WIDTH(SW), .LAGS(LAGS), .MAX_BLOCK(MAXB), .OUT_WIDTH(OW)
    ) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iBlockSize(iBlockSize),
        .iValid(iValid), .oReady(oReady), .iSample(iSample), .oValid(oValid),
        .iOutReady(iOutReady), .oAcf(oAcf), .oLag(oLag), .oShift(oShift),
        .oLast(oLast), .oBlockDone(oBlockDone)
    );

    typedef struct {
        longint acf;
        int     lag;
        int     shift;
        bit     last;
    } beat_t;

    beat_t  expq[$];
    longint log_q[$];
    int     log_shift;
    int     total = 0;
    int     bad = 0;
    int     done_cnt = 0;
    int     blk[0:MAXB-1];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected beats for one block straight from R[k] = sum x[n]*x[n-k]
    function automatic void model_push(input int len);
        longint r[0:LAGS];
        int s;
        beat_t b;
        for (int k = 0; k <= LAGS; k++) begin
            r[k] = 0;
            for (int n = k; n < len; n++) r[k] += longint'(blk[n]) * longint'(blk[n-k]);
        end
        s = 0;
        while ((r[0] >>> s) >= (longint'(1) <<< (OW - 1))) s++;
        for (int k = 0; k <= LAGS; k++) begin
            b.acf = r[k] >>> s;
            b.lag = k;
            b.shift = s;
            b.last = (k == LAGS);
            expq.push_back(b);
        end
    endfunction

    // Scoreboard: every valid beat must match the head of the expected queue
    always @(negedge iClock) begin : compare
        beat_t b;
        if (!iReset) begin
            if (oBlockDone) done_cnt++;
            if (oValid) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: lag=%0d acf=%0d with no block pending", oLag, oAcf);
                end else begin
                    b = expq[0];
                    if (oAcf != b.acf || oLag != b.lag || oShift != b.shift || oLast != b.last) begin
                        bad++;
                        $display("FAIL beat: got lag=%0d acf=%0d shift=%0d last=%0b expected lag=%0d acf=%0d shift=%0d last=%0b",
                                 oLag, oAcf, oShift, oLast, b.lag, b.acf, b.shift, b.last);
                    end
                    if (iOutReady && iEnable) begin
                        log_q.push_back(longint'(oAcf));
                        log_shift = oShift;
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_sample(input int x);
        bit done = 1'b0;
        iValid = 1'b1;
        iSample = SW'(x);
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge iClock);
            if (oReady && iEnable) done = 1'b1;
            @(posedge iClock);
            #1;
        end
        if (!done) check("sample_accept_timeout", 0, 1);
    endtask

    task automatic feed(input int len, input int size_in, input bit push, input bit scramble);
        if (push) model_push(len);
        iBlockSize = BSW'(size_in);
        for (int i = 0; i < len; i++) begin
            send_sample(blk[i]);
            if (i == 0 && scramble) iBlockSize = BSW'(1);
        end
        iValid = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((expq.size() != 0 || oValid) && c < 20000) begin
            @(negedge iClock);
            c++;
        end
        check("drain_timeout", longint'(expq.size()), 0);
        repeat (2) @(posedge iClock);
        #1;
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        blk[0] = a; blk[1] = b; blk[2] = c; blk[3] = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, oValid, 0);
        check({tag, "_ready"}, oReady, 1);
        check({tag, "_acf"},   oAcf, 0);
        check({tag, "_lag"},   oLag, 0);
        check({tag, "_shift"}, oShift, 0);
        check({tag, "_last"},  oLast, 0);
        check({tag, "_done"},  oBlockDone, 0);
    endtask

    task automatic start_test();
        log_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int lag0;
        iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iOutReady = 1'b1;
        iSample = '0; iBlockSize = BSW'(4);
        repeat (2) @(posedge iClock);
        #1;
        check_reset_outputs("rst");
        iReset = 1'b0;

        // Basic block
        start_test();
        set4(1, 2, 3, 4);
        feed(4, 4, 1'b1, 1'b0);
        wait_drain();
        check("t1_count", longint'(log_q.size()), 3);
        check("t1_r0", log_q[0], 30);
        check("t1_r1", log_q[1], 20);
        check("t1_r2", log_q[2], 11);
        check("t1_shift", log_shift, 0);
        check("t1_done", done_cnt, 1);

        // Back-to-back blocks with an enable freeze during output
        start_test();
        set4(1, 2, 3, 4);
        feed(4, 4, 1'b1, 1'b0);
        set4(5, 5, 5, 5);
        feed(4, 4, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !oValid; c++) @(negedge iClock);
        @(posedge iClock);
        #1;
        lag0 = oLag;
        iEnable = 1'b0;
        repeat (4) @(posedge iClock);
        #1;
        check("freeze_lag", oLag, lag0);
        iEnable = 1'b1;
        wait_drain();
        check("t2_count", longint'(log_q.size()), 6);
        check("t2_r0", log_q[3], 100);
        check("t2_r1", log_q[4], 75);
        check("t2_r2", log_q[5], 50);
        check("t2_done", done_cnt, 2);

        // Signed samples; block size change after first sample is ignored
        start_test();
        blk[0] = 3; blk[1] = -2; blk[2] = 7; blk[3] = -5; blk[4] = 1;
        feed(5, 5, 1'b1, 1'b1);
        wait_drain();
        check("t3_r0", log_q[0], 88);
        check("t3_r1", log_q[1], -60);
        check("t3_r2", log_q[2], 38);

        // Backpressure across three blocks
        start_test();
        iOutReady = 1'b0;
        set4(1, 2, 3, 4);
        feed(4, 4, 1'b1, 1'b0);
        set4(2, 0, -1, 3);
        feed(4, 4, 1'b1, 1'b0);
        set4(5, 5, 5, 5);
        fork
            feed(4, 4, 1'b1, 1'b0);
            begin
                repeat (30) @(posedge iClock);
                #1;
                check("bp_ready_low", oReady, 0);
                check("bp_valid", oValid, 1);
                check("bp_lag_hold", oLag, 0);
                check("bp_done_one", done_cnt, 1);
                iOutReady = 1'b1;
            end
        join
        wait_drain();
        check("t4_count", longint'(log_q.size()), 9);
        check("t4_b1_r0", log_q[0], 30);
        check("t4_b2_r0", log_q[3], 14);
        check("t4_b2_r1", log_q[4], -3);
        check("t4_b2_r2", log_q[5], -2);
        check("t4_b3_r0", log_q[6], 100);
        check("t4_b3_r2", log_q[8], 50);
        check("t4_done", done_cnt, 3);

        // Full-scale block, size 0 means MAX_BLOCK, exercises normalisation
        start_test();
        for (int i = 0; i < MAXB; i++) blk[i] = -32768;
        feed(MAXB, 0, 1'b1, 1'b0);
        wait_drain();
        check("t5_shift", log_shift, 28);
        check("t5_r0", log_q[0], 16384);
        check("t5_r1", log_q[1], 16380);
        check("t5_r2", log_q[2], 16376);

        // Oversize block request clamps to MAX_BLOCK
        start_test();
        for (int i = 0; i < MAXB; i++) blk[i] = 1;
        feed(MAXB, MAXB + 1, 1'b1, 1'b0);
        wait_drain();
        check("t6_r0", log_q[0], 4096);
        check("t6_r1", log_q[1], 4095);
        check("t6_r2", log_q[2], 4094);
        check("t6_shift", log_shift, 0);

        // Reset mid-drain and mid-block discards everything
        start_test();
        iOutReady = 1'b0;
        set4(7, 7, 7, 7);
        feed(4, 4, 1'b1, 1'b0);
        set4(9, 9, 0, 0);
        feed(2, 4, 1'b0, 1'b0);
        repeat (3) @(posedge iClock);
        #1;
        iReset = 1'b1;
        repeat (2) @(posedge iClock);
        #1;
        check_reset_outputs("midrst");
        expq.delete();
        iReset = 1'b0;
        iOutReady = 1'b1;
        start_test();
        set4(1, 2, 3, 4);
        feed(4, 4, 1'b1, 1'b0);
        wait_drain();
        check("t7_count", longint'(log_q.size()), 3);
        check("t7_r0", log_q[0], 30);
        check("t7_r1", log_q[1], 20);
        check("t7_r2", log_q[2], 11);
        check("t7_done", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acf_stream_engine.md
Name: acf_stream_engine

Overview:
- Parametrised integer autocorrelation engine for the encoder's LPC front end.
- Accumulates R[k] = sum x[n]*x[n-k], for k = 0..LAGS, over runtime-sized blocks of signed samples.
- History is zeroed at every block start, so no cross-block terms are accumulated.
- Each completed block is normalised by one common right shift and streamed out one lag per beat on a valid/ready interface. A double-buffered output bank lets block N+1 accumulate while block N drains.

Parameters:
- SAMPLE_WIDTH, 16, signed input sample width.
- LAGS, 12, highest lag computed; LAGS+1 values per block.
- MAX_BLOCK, 4096, largest block size in samples.
- OUT_WIDTH, 32, signed width of each output value.
- ACC_WIDTH = 2*SAMPLE_WIDTH + $clog2(MAX_BLOCK) + 1 (derived, local).

Ports:
- iClock, in, 1, clock.
- iReset, in, 1, synchronous active-high reset.
- iEnable, in, 1, global enable; when low, nothing advances and all state holds.
- iBlockSize, in, $clog2(MAX_BLOCK)+1, block length; sampled on a block's first accepted sample. 0 or >MAX_BLOCK means MAX_BLOCK.
- iValid, in, 1, iSample is valid.
- oReady, out, 1, engine accepts a sample this cycle.
- iSample, in, SAMPLE_WIDTH, signed sample.
- oValid, out, 1, oAcf/oLag/oShift/oLast are valid.
- iOutReady, in, 1, downstream accepts the output beat.
- oAcf, out, OUT_WIDTH, signed normalised R[oLag].
- oLag, out, $clog2(LAGS+1), lag index, 0 first.
- oShift, out, 6, common right shift applied to this block.
- oLast, out, 1, high on the lag=LAGS beat.
- oBlockDone, out, 1, one-cycle pulse when a block's sums are transferred to the output bank.

Behaviour:
- Reset (iReset high at posedge, priority over all): accumulators, history, counters, both banks cleared. Outputs: oValid=0, oReady=1, oAcf=0, oLag=0, oShift=0, oLast=0, oBlockDone=0.
- Sample acceptance: accept = iEnable & iValid & oReady.
- History: on accept, the history shift register takes x[n]. When n=0 of a block, all older history taps are treated as 0.
- Stage 1 (registered): p[k] = x[n]*h[k], full 2*SAMPLE_WIDTH signed.
- Stage 2: acc[k] += sign-extended p[k]. ACC_WIDTH guarantees no overflow.
- Latency: last sample accepted at cycle t; its product lands in acc at t+2.
- Accumulator FSM states: ACCUM, FLUSH, XFER, STALL.
  - ACCUM: counts accepted samples. On the BLOCK_SIZE-th accept, go to FLUSH.
  - FLUSH: 2 cycles, oReady=0, pipeline drains.
  - XFER: if the output bank is empty, copy acc[0..LAGS] into the output bank in one cycle. Same cycle: clear acc, history and count; pulse oBlockDone; return to ACCUM with oReady=1 the next cycle.
  - STALL: entered from XFER if the output bank is busy. oReady=0 until the bank frees, then XFER.
- Normalisation: performed on transfer, combinational or in one extra cycle before oValid.
  - s = smallest value such that (R[0] >> s) < 2^(OUT_WIDTH-1).
  - Every lag is arithmetic-right-shifted by s. Since |R[k]| <= R[0], all lags fit.
  - R[0]=0 (all-zero block) gives s=0 and all outputs 0.
- Output FSM states: EMPTY, SEND.
  - SEND: oValid=1, lag index advances on oValid & iOutReady.
  - While iOutReady is low, the beat holds stable (oAcf, oLag, oShift, oLast unchanged).
  - After the handshake with oLast=1: if no transfer is pending, go EMPTY with oValid=0 the next cycle. A transfer landing in the same cycle as the last handshake is allowed; oValid stays 1 with lag 0 of the new block.
- iEnable low: freezes both FSMs, pipeline and counters; a handshake cannot complete.
- Block size changes mid-block are ignored until the next block start.
- Reset mid-block or mid-drain: the partial block and the undrained bank are discarded.

Test Plan:
- LAGS=2, OUT_WIDTH=32, iBlockSize=4, samples 1,2,3,4, iOutReady=1 -> beats (lag, oAcf) = (0,30), (1,20), (2,11); oShift=0; oLast on lag 2; one oBlockDone pulse.
- Back-to-back blocks: samples 1,2,3,4 then 5,5,5,5, same config -> second block outputs 100, 75, 50. No 4*5 cross term.
- Normalisation: SAMPLE_WIDTH=16, OUT_WIDTH=16, LAGS=2, block 4096 of -32768 -> oShift=28; oAcf = 16384, 16380, 16376.
- Backpressure: iOutReady=0, feed three 4-sample blocks back-to-back.
  - Block 1 outputs hold at lag 0.
  - Block 2 transfers only after block 1 drains; oReady is low from the end of block 2 until then.
  - No samples are lost; all three blocks emerge in order with correct values.
- iBlockSize=0 with MAX_BLOCK=8, samples all 1 -> 8 samples accepted; outputs 8, 7, 6.
- Reset asserted after 2 of 4 samples, then block 1,2,3,4 -> outputs 30, 20, 11 with no residue. Outputs are at reset values during reset.
